fetch_buffer_unit: RTL and testbench

FETCH_BUFFER_UNIT -- requirements
Module: fetch_buffer_unit

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 37 +++
 rtl/fetch_buffer_unit.sv | 54 +++++
 tb/tb_fetch_buffer_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and helpers for the fetch buffer unit
// Holds the PC increment, the default reset PC and the queue-entry width helper.
package fetch_pkg;
    localparam int unsigned PC_STEP = 4;
    localparam int unsigned DEFAULT_RESET_PC = 0;
    function automatic int entry_width(input int addr_width, input int data_width);
        return addr_width + data_width;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular fetch queue with flush and occupancy count
// Ports: clk, rst (sync, active-high), push/wdata (write at tail), pop (advance head),
// flush (empty queue), rdata (head entry), count (occupancy).
// The caller never pushes when full without a pop, and never pops when empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] head, tail;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
            count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
        end
    end
    // Storage is left unreset; the top masks the head whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= wdata;
    end
    assign rdata = mem[head];
endmodule

// File: rtl/fetch_buffer_unit.sv
// fetch_buffer_unit: PC register and fetch control feeding a decoupled fetch queue
// Ports: Clk, Reset (sync, active-high), Fetch_En, ID_PCSrc/ID_new_PC (redirect),
// ID_Ready (head consumed), IMem_Addr/IMem_Data (combinational instruction memory),
// IF_Valid/IF_Instruction/IF_PC4 (head entry, zero when empty), IF_Count (occupancy).
module fetch_buffer_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Fetch_En,
    input  logic                     ID_PCSrc,
    input  logic [ADDR_WIDTH-1:0]    ID_new_PC,
    input  logic                     ID_Ready,
    output logic [ADDR_WIDTH-1:0]    IMem_Addr,
    input  logic [DATA_WIDTH-1:0]    IMem_Data,
    output logic                     IF_Valid,
    output logic [DATA_WIDTH-1:0]    IF_Instruction,
    output logic [ADDR_WIDTH-1:0]    IF_PC4,
    output logic [$clog2(DEPTH):0]   IF_Count
);
    localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [ADDR_WIDTH-1:0] pc, pc4;
    logic [EW-1:0] head;
    logic push, pop;
    assign pc4 = pc + ADDR_WIDTH'(PC_STEP);
    assign IF_Valid = IF_Count != '0;
    assign pop = IF_Valid & ID_Ready & ~ID_PCSrc;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    assign push = Fetch_En & ~ID_PCSrc & ((IF_Count < CW'(DEPTH)) | pop);
    always_ff @(posedge Clk) begin
        if (Reset) pc <= RESET_PC;
        else if (ID_PCSrc) pc <= ID_new_PC & ~ADDR_WIDTH'(3);
        else if (push) pc <= pc4;
    end
    fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk(Clk),
        .rst(Reset),
        .push(push),
        .pop(pop),
        .flush(ID_PCSrc),
        .wdata({pc4, IMem_Data}),
        .rdata(head),
        .count(IF_Count)
    );
    assign IMem_Addr = pc;
    assign IF_Instruction = IF_Valid ? head[DATA_WIDTH-1:0] : '0;
    assign IF_PC4 = IF_Valid ? head[EW-1:DATA_WIDTH] : '0;
endmodule

// File: tb/tb_fetch_buffer_unit.sv
// tb_fetch_buffer_unit: directed self-checking bench for fetch_buffer_unit
module tb_fetch_buffer_unit;
    logic        Clk = 1'b0;
    logic        Reset, Fetch_En, ID_PCSrc, ID_Ready;
    logic [31:0] ID_new_PC, IMem_Addr, IMem_Data, IF_Instruction, IF_PC4;
    logic        IF_Valid;
    logic [2:0]  IF_Count;
    int tests = 0;
    int fails = 0;

    fetch_buffer_unit dut (
        .Clk(Clk), .Reset(Reset), .Fetch_En(Fetch_En), .ID_PCSrc(ID_PCSrc),
        .ID_new_PC(ID_new_PC), .ID_Ready(ID_Ready), .IMem_Addr(IMem_Addr),
        .IMem_Data(IMem_Data), .IF_Valid(IF_Valid), .IF_Instruction(IF_Instruction),
        .IF_PC4(IF_PC4), .IF_Count(IF_Count)
    );

    always #5 Clk = ~Clk;
    assign IMem_Data = IMem_Addr;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic head(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
        chk({tag, "_valid"}, 64'(IF_Valid), 64'(v));
        chk({tag, "_instr"}, 64'(IF_Instruction), 64'(ins));
        chk({tag, "_pc4"}, 64'(IF_PC4), 64'(p4));
    endtask

    initial begin
        Reset = 1; Fetch_En = 0; ID_PCSrc = 0; ID_Ready = 0; ID_New_init();
        tick(); tick();
        head("rst", 0, 0, 0);
        chk("rst_count", 64'(IF_Count), 0);
        chk("rst_addr", 64'(IMem_Addr), 0);

        // streaming fetch with decode always ready
        Reset = 0; Fetch_En = 1; ID_Ready = 1;
        tick();
        head("s0", 1, 32'h0, 32'h4);
        chk("s0_addr", 64'(IMem_Addr), 64'h4);
        chk("s0_count", 64'(IF_Count), 1);
        tick();
        head("s1", 1, 32'h4, 32'h8);
        tick();
        head("s2", 1, 32'h8, 32'hC);
        chk("s2_count", 64'(IF_Count), 1);

        // fill to full with decode stalled
        Reset = 1; tick();
        Reset = 0; ID_Ready = 0;
        tick();
        chk("f1_count", 64'(IF_Count), 1);
        tick(); tick(); tick(); tick(); tick();
        chk("full_count", 64'(IF_Count), 4);
        chk("full_addr", 64'(IMem_Addr), 64'h10);
        head("full", 1, 32'h0, 32'h4);

        // drain while refetching: order kept, count stays full
        ID_Ready = 1;
        tick();
        head("d1", 1, 32'h4, 32'h8);
        chk("d1_count", 64'(IF_Count), 4);
        chk("d1_addr", 64'(IMem_Addr), 64'h14);
        tick();
        head("d2", 1, 32'h8, 32'hC);
        tick();
        head("d3", 1, 32'hC, 32'h10);
        chk("d3_count", 64'(IF_Count), 4);
        chk("d3_addr", 64'(IMem_Addr), 64'h1C);

        // redirect from full queue to unaligned target
        ID_PCSrc = 1; ID_new_PC = 32'h103;
        tick();
        head("r0", 0, 0, 0);
        chk("r0_count", 64'(IF_Count), 0);
        chk("r0_addr", 64'(IMem_Addr), 64'h100);
        ID_PCSrc = 0;
        tick();
        head("r1", 1, 32'h100, 32'h104);
        chk("r1_count", 64'(IF_Count), 1);

        // fetch disabled: drain continues, PC holds
        Fetch_En = 0;
        tick();
        chk("fe0_count", 64'(IF_Count), 0);
        chk("fe0_addr", 64'(IMem_Addr), 64'h104);
        tick();
        chk("fe1_addr", 64'(IMem_Addr), 64'h104);
        head("fe1", 0, 0, 0);
        ID_PCSrc = 1; ID_new_PC = 32'hFFFF_FFFC;
        tick();
        chk("fe_redir_addr", 64'(IMem_Addr), 64'hFFFF_FFFC);

        // PC wrap at top of address space
        ID_PCSrc = 0; Fetch_En = 1; ID_Ready = 0;
        tick();
        head("w0", 1, 32'hFFFF_FFFC, 32'h0);
        chk("w0_addr", 64'(IMem_Addr), 0);
        tick(); tick();
        chk("w2_count", 64'(IF_Count), 3);
        chk("w2_addr", 64'(IMem_Addr), 64'h8);

        // reset mid-stream beats a concurrent redirect
        Reset = 1; ID_PCSrc = 1; ID_new_PC = 32'h200;
        tick();
        chk("mr_count", 64'(IF_Count), 0);
        chk("mr_addr", 64'(IMem_Addr), 0);
        head("mr", 0, 0, 0);
        Reset = 0; ID_PCSrc = 0; ID_Ready = 1;
        tick();
        head("mr1", 1, 32'h0, 32'h4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    task automatic ID_New_init();
        ID_new_PC = '0;
    endtask
endmodule
